// File: rtl/msp430_mem_pkg.sv
// ----------------------------------------------------------------------------
// msp430_mem_pkg
// Shared types and constants for the CPU memory-bus responder.
//   state_e        : responder FSM states (IDLE / WAIT / RESP)
//   region_e       : decoded target of an access
//   VEC_ADDR       : byte address of the reset vector word
//   UNMAPPED_DATA  : read data returned for unmapped addresses
//   decode_region  : maps a byte address to a region
// ----------------------------------------------------------------------------
package msp430_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_RAM  = 2'd1,
        REG_VEC  = 2'd2
    } region_e;

    localparam logic [15:0] VEC_ADDR      = 16'hFFFE;
    localparam logic [15:0] UNMAPPED_DATA = 16'h0000;

    // The RAM offset is taken modulo 2^16, so an address below the base
    // wraps to a large offset and falls outside the window.
    function automatic region_e decode_region(input logic [15:0]   addr,
                                              input logic [15:0]   ram_base,
                                              input int unsigned   ram_words);
        logic [15:0] offset;
        offset = addr - ram_base;
        if (addr[15:1] == VEC_ADDR[15:1]) begin
            return REG_VEC;
        end
        if ({16'h0000, offset} < (ram_words << 1)) begin
            return REG_RAM;
        end
        return REG_NONE;
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// ----------------------------------------------------------------------------
// mem_bus_responder_if
// CPU memory bus between the fetch/execute pipeline and the memory responder.
//   MAB      byte address              (master -> slave)
//   MDB_out  write data                (master -> slave)
//   mem_req  access request, level     (master -> slave)
//   mem_we   1 = write, 0 = read       (master -> slave)
//   mem_bw   1 = byte, 0 = word        (master -> slave)
//   MDB_in   read data                 (slave -> master)
//   mem_rdy  access complete pulse     (slave -> master)
//   bus_err  illegal access pulse      (slave -> master)
// ----------------------------------------------------------------------------
interface mem_bus_responder_if;

    logic [15:0] MAB;
    logic [15:0] MDB_out;
    logic        mem_req;
    logic        mem_we;
    logic        mem_bw;
    logic [15:0] MDB_in;
    logic        mem_rdy;
    logic        bus_err;

    modport master (
        output MAB,
        output MDB_out,
        output mem_req,
        output mem_we,
        output mem_bw,
        input  MDB_in,
        input  mem_rdy,
        input  bus_err
    );

    modport slave (
        input  MAB,
        input  MDB_out,
        input  mem_req,
        input  mem_we,
        input  mem_bw,
        output MDB_in,
        output mem_rdy,
        output bus_err
    );

endinterface

// File: rtl/mem_ram_array.sv
// ----------------------------------------------------------------------------
// mem_ram_array
// Single-port RAM of WORDS x 16 bits with independent byte-lane write enables.
// Writes happen on the rising clock edge; the read port is combinational.
//   clk       in   clock
//   we_lo_i   in   write enable for bits [7:0]
//   we_hi_i   in   write enable for bits [15:8]
//   idx_i     in   word index
//   wdata_i   in   write data (both lanes)
//   rdata_o   out  word at idx_i
// Contents are deliberately not reset.
// ----------------------------------------------------------------------------
module mem_ram_array #(
    parameter  int unsigned WORDS = 512,
    localparam int          IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             we_lo_i,
    input  logic             we_hi_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [15:0]      wdata_i,
    output logic [15:0]      rdata_o
);

    logic [15:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we_lo_i) begin
            mem_q[idx_i][7:0] <= wdata_i[7:0];
        end
        if (we_hi_i) begin
            mem_q[idx_i][15:8] <= wdata_i[15:8];
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_bus_responder.sv
// ----------------------------------------------------------------------------
// mem_bus_responder
// Memory-side responder for the CPU memory bus: RAM window, read-only reset
// vector at 16'hFFFE, configurable wait states, req/rdy handshake.
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   bus   slave modport of mem_bus_responder_if
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for mem_req; access fields latched on accept
//   WAIT  | burning WAIT_STATES cycles before the response
//   RESP  | access resolved; registered mem_rdy/bus_err/MDB_in set on exit
//
// Outputs are registered, so the mem_rdy pulse appears in the cycle after
// RESP, while the FSM is already back in IDLE. The master drops mem_req on
// seeing mem_rdy, which keeps back-to-back throughput at WAIT_STATES+2.
// ----------------------------------------------------------------------------
module mem_bus_responder
    import msp430_mem_pkg::*;
#(
    parameter logic [15:0] RAM_BASE     = 16'h0200,
    parameter int unsigned RAM_WORDS    = 512,
    parameter int unsigned WAIT_STATES  = 0,
    parameter logic [15:0] RESET_VECTOR = 16'hC000
) (
    input logic               clk,
    input logic               rst,
    mem_bus_responder_if.slave bus
);

    localparam int          IDX_W   = $clog2(RAM_WORDS);
    localparam logic [2:0]  WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic        bw_q;
    logic [15:0] mdb_in_q, mdb_in_d;
    logic        rdy_q, rdy_d;
    logic        err_q, err_d;

    // Access view: live bus fields while accepting, latched fields otherwise.
    // A zero-wait write commits on the accept edge itself, before the
    // latches hold anything.
    logic [15:0] cur_addr;
    logic [15:0] cur_wdata;
    logic        cur_we;
    logic        cur_bw;
    region_e     cur_region;

    logic [IDX_W-1:0] ram_idx;
    logic             ram_we_lo;
    logic             ram_we_hi;
    logic [15:0]      ram_wdata;
    logic [15:0]      ram_rdata;
    logic [15:0]      rd_data;

    always_comb begin
        if (state_q == IDLE) begin
            cur_addr  = bus.MAB;
            cur_wdata = bus.MDB_out;
            cur_we    = bus.mem_we;
            cur_bw    = bus.mem_bw;
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_we    = we_q;
            cur_bw    = bw_q;
        end
        cur_region = decode_region(cur_addr, RAM_BASE, RAM_WORDS);
        ram_idx    = IDX_W'((cur_addr - RAM_BASE) >> 1);
        // A byte write always carries its data in MDB_out[7:0]; replicate it
        // so whichever lane is enabled sees it.
        ram_wdata  = cur_bw ? {cur_wdata[7:0], cur_wdata[7:0]} : cur_wdata;
    end

    mem_ram_array #(
        .WORDS (RAM_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_lo_i (ram_we_lo),
        .we_hi_i (ram_we_hi),
        .idx_i   (ram_idx),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        rd_data = UNMAPPED_DATA;
        case (cur_region)
            REG_RAM: begin
                if (cur_bw) begin
                    rd_data = {8'h00, cur_addr[0] ? ram_rdata[15:8] : ram_rdata[7:0]};
                end else begin
                    rd_data = ram_rdata;
                end
            end
            REG_VEC: begin
                if (cur_bw) begin
                    rd_data = {8'h00, cur_addr[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0]};
                end else begin
                    rd_data = RESET_VECTOR;
                end
            end
            default: rd_data = UNMAPPED_DATA;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdb_in_d  = mdb_in_q;
        rdy_d     = 1'b0;
        err_d     = 1'b0;
        ram_we_lo = 1'b0;
        ram_we_hi = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                    cnt_d   = WS_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
                err_d   = (cur_region == REG_NONE) || (cur_region == REG_VEC && cur_we);
                if (!cur_we) begin
                    mdb_in_d = rd_data;
                end
            end
            default: state_d = IDLE;
        endcase

        // Commit on the edge that enters RESP; reset on that edge aborts it.
        if (!rst && state_d == RESP && state_q != RESP && cur_we && cur_region == REG_RAM) begin
            ram_we_lo = !cur_bw || !cur_addr[0];
            ram_we_hi = !cur_bw ||  cur_addr[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            we_q     <= 1'b0;
            bw_q     <= 1'b0;
            mdb_in_q <= 16'h0000;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mdb_in_q <= mdb_in_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
            if (state_q == IDLE && bus.mem_req) begin
                addr_q  <= bus.MAB;
                wdata_q <= bus.MDB_out;
                we_q    <= bus.mem_we;
                bw_q    <= bus.mem_bw;
            end
        end
    end

    assign bus.MDB_in  = mdb_in_q;
    assign bus.mem_rdy = rdy_q;
    assign bus.bus_err = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_responder
// Two responders share the clock: dut0 with no wait states, dut1 with three.
// A byte-addressed memory model predicts each access when it is issued; the
// compare process checks mem_rdy timing, read data and bus_err every cycle.
// ----------------------------------------------------------------------------
module tb_mem_bus_responder;

    localparam logic [15:0] RAM_BASE  = 16'h0200;
    localparam int          RAM_WORDS = 512;
    localparam logic [15:0] RV        = 16'hC000;

    typedef struct {
        int          due;
        logic        is_wr;
        logic [15:0] d;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    exp_t        expq [2][$];
    logic [15:0] held [2];
    logic [7:0]  mram [2][2*RAM_WORDS];

    mem_bus_responder_if bus0 ();
    mem_bus_responder_if bus1 ();

    mem_bus_responder #(
        .RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS), .WAIT_STATES(0), .RESET_VECTOR(RV)
    ) dut0 (.clk(clk), .rst(rst0), .bus(bus0));

    mem_bus_responder #(
        .RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS), .WAIT_STATES(3), .RESET_VECTOR(RV)
    ) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    task automatic drive(input int k, input logic req, input logic [15:0] a, input logic we,
                         input logic bw, input logic [15:0] wd);
        if (k == 0) begin
            bus0.mem_req = req; bus0.MAB = a; bus0.mem_we = we; bus0.mem_bw = bw; bus0.MDB_out = wd;
        end else begin
            bus1.mem_req = req; bus1.MAB = a; bus1.mem_we = we; bus1.mem_bw = bw; bus1.MDB_out = wd;
        end
    endtask

    // Byte-addressed model: byte at RAM offset b lives in lane b[0].
    function automatic void model_exec(input int k, input logic [15:0] a, input logic we, input logic bw,
                                       input logic [15:0] wd, output logic [15:0] d, output logic e);
        int b;
        d = 16'h0000;
        e = 1'b0;
        if (a >= 16'hFFFE) begin
            if (we) e = 1'b1;
            else if (!bw) d = RV;
            else d = a[0] ? {8'h00, RV[15:8]} : {8'h00, RV[7:0]};
        end else if (a >= RAM_BASE && int'(a) < int'(RAM_BASE) + 2 * RAM_WORDS) begin
            b = int'(a) - int'(RAM_BASE);
            if (bw) begin
                if (we) mram[k][b] = wd[7:0];
                else d = {8'h00, mram[k][b]};
            end else begin
                b = b - (b % 2);
                if (we) begin
                    mram[k][b]     = wd[7:0];
                    mram[k][b + 1] = wd[15:8];
                end else begin
                    d = {mram[k][b + 1], mram[k][b]};
                end
            end
        end else begin
            e = 1'b1;
        end
    endfunction

    task automatic cmp_inst(input int k, input logic rdy, input logic err, input logic [15:0] d);
        exp_t        e;
        logic        exp_rdy;
        logic [15:0] expd;
        exp_rdy = (expq[k].size() > 0) && (expq[k][0].due == cyc);
        check("mem_rdy", k, {15'b0, rdy}, {15'b0, exp_rdy});
        if (exp_rdy) begin
            e    = expq[k].pop_front();
            expd = e.is_wr ? held[k] : e.d;
            check("MDB_in", k, d, expd);
            check("bus_err", k, {15'b0, err}, {15'b0, e.err});
            held[k] = expd;
        end else begin
            check("bus_err_idle", k, {15'b0, err}, 16'h0000);
            if (expq[k].size() > 0 && expq[k][0].due < cyc) void'(expq[k].pop_front());
        end
    endtask

    always @(negedge clk) begin
        cmp_inst(0, bus0.mem_rdy, bus0.bus_err, bus0.MDB_in);
        cmp_inst(1, bus1.mem_rdy, bus1.bus_err, bus1.MDB_in);
    end

    // Issues one access, records the model's prediction, and returns what the
    // master saw plus the latency in cycles from raising mem_req.
    task automatic access(input int k, input logic [15:0] a, input logic we, input logic bw,
                          input logic [15:0] wd, output logic [15:0] rd, output logic err, output int lat);
        exp_t        e;
        logic [15:0] md;
        logic        me;
        logic        got;
        @(negedge clk);
        #1;
        model_exec(k, a, we, bw, wd, md, me);
        e.due = cyc + 2 + ws_of(k);
        e.is_wr = we;
        e.d = md;
        e.err = me;
        expq[k].push_back(e);
        drive(k, 1'b1, a, we, bw, wd);
        got = 1'b0; lat = 0; rd = 16'h0000; err = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            #2;
            if ((k == 0) ? bus0.mem_rdy : bus1.mem_rdy) begin
                got = 1'b1;
                lat = i;
                rd  = (k == 0) ? bus0.MDB_in : bus1.MDB_in;
                err = (k == 0) ? bus0.bus_err : bus1.bus_err;
            end
        end
        drive(k, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL handshake_timeout dut%0d: no mem_rdy for addr %h within 20 cycles", k, a);
        end
    endtask

    // Starts a write, then resets the responder while it sits in WAIT.
    task automatic abort_write(input int k, input logic [15:0] a, input logic [15:0] wd);
        @(negedge clk);
        #1;
        drive(k, 1'b1, a, 1'b1, 1'b0, wd);
        repeat (2) @(negedge clk);
        #1;
        if (k == 0) rst0 = 1'b1; else rst1 = 1'b1;
        drive(k, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        held[k] = 16'h0000;
        @(negedge clk);
        #1;
        if (k == 0) rst0 = 1'b0; else rst1 = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;

        held[0] = 16'h0000;
        held[1] = 16'h0000;
        rst0 = 1'b1;
        rst1 = 1'b1;
        drive(0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        drive(1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_MDB_in", 0, bus0.MDB_in, 16'h0000);
        check("rst_mem_rdy", 0, {15'b0, bus0.mem_rdy}, 16'h0000);
        check("rst_bus_err", 1, {15'b0, bus1.bus_err}, 16'h0000);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Reset-vector fetch
        access(0, 16'hFFFE, 1'b0, 1'b0, 16'h0000, rd, er, lat);
        check("t1_latency", 0, 16'(lat), 16'd2);
        check("t1_vector", 0, rd, 16'hC000);
        check("t1_err", 0, {15'b0, er}, 16'h0000);

        // Word write and aligned reads
        access(0, 16'h0200, 1'b1, 1'b0, 16'hBEEF, rd, er, lat);
        access(0, 16'h0200, 1'b0, 1'b0, 16'h0000, rd, er, lat);
        check("t2_read_0200", 0, rd, 16'hBEEF);
        access(0, 16'h0201, 1'b0, 1'b0, 16'h0000, rd, er, lat);
        check("t2_read_0201", 0, rd, 16'hBEEF);

        // Byte write into high lane
        access(0, 16'h0202, 1'b1, 1'b0, 16'h1234, rd, er, lat);
        access(0, 16'h0203, 1'b1, 1'b1, 16'hFF5A, rd, er, lat);
        access(0, 16'h0202, 1'b0, 1'b0, 16'h0000, rd, er, lat);
        check("t3_word_0202", 0, rd, 16'h5A34);
        access(0, 16'h0203, 1'b0, 1'b1, 16'h0000, rd, er, lat);
        check("t3_byte_0203", 0, rd, 16'h005A);
        access(0, 16'h0202, 1'b0, 1'b1, 16'h0000, rd, er, lat);
        check("t3_byte_0202", 0, rd, 16'h0034);

        // Unmapped and vector-write errors
        access(0, 16'h0100, 1'b0, 1'b0, 16'h0000, rd, er, lat);
        check("t4_unmapped_rd", 0, rd, 16'h0000);
        check("t4_unmapped_err", 0, {15'b0, er}, 16'h0001);
        access(0, 16'hFFFE, 1'b1, 1'b0, 16'h1111, rd, er, lat);
        check("t4_vecwr_err", 0, {15'b0, er}, 16'h0001);
        access(0, 16'hFFFE, 1'b0, 1'b0, 16'h0000, rd, er, lat);
        check("t4_vector_kept", 0, rd, 16'hC000);
        access(0, 16'hFFFF, 1'b0, 1'b1, 16'h0000, rd, er, lat);
        check("t4_vec_hibyte", 0, rd, 16'h00C0);

        // Window edges
        access(0, 16'h05FE, 1'b1, 1'b0, 16'h7E57, rd, er, lat);
        access(0, 16'h05FF, 1'b0, 1'b0, 16'h0000, rd, er, lat);
        check("edge_last_word", 0, rd, 16'h7E57);
        access(0, 16'h0600, 1'b0, 1'b0, 16'h0000, rd, er, lat);
        check("edge_past_end_err", 0, {15'b0, er}, 16'h0001);
        access(0, 16'h01FF, 1'b1, 1'b1, 16'h0055, rd, er, lat);
        check("edge_below_base_err", 0, {15'b0, er}, 16'h0001);

        // Three wait states, mem_req held through WAIT
        access(1, 16'h0204, 1'b1, 1'b0, 16'h1111, rd, er, lat);
        check("t5_wr_latency", 1, 16'(lat), 16'd5);
        access(1, 16'hFFFE, 1'b0, 1'b0, 16'h0000, rd, er, lat);
        check("t5_rd_latency", 1, 16'(lat), 16'd5);
        check("t5_vector", 1, rd, 16'hC000);

        // Reset during WAIT aborts the write
        abort_write(1, 16'h0204, 16'hAAAA);
        repeat (8) @(negedge clk);
        check("t6_MDB_in_after_rst", 1, bus1.MDB_in, 16'h0000);
        access(1, 16'h0204, 1'b0, 1'b0, 16'h0000, rd, er, lat);
        check("t6_prior_value", 1, rd, 16'h1111);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
